// File: rtl/fetch_pkg.sv
// Shared types and constants for the IF-stage fetch controller.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DROP,
        STALL
    } fetch_state_t;

    localparam logic [31:0] NOP              = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam int unsigned PC_INC           = 4;

endpackage

// File: rtl/fetch_hold_buf.sv
// Single-entry holding register for an instruction fetched while decode is stalled.
module fetch_hold_buf #(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              clear,
    input  logic [31:0]       instr_in,
    input  logic [ADDR_W-1:0] npc_in,
    output logic [31:0]       instr,
    output logic [ADDR_W-1:0] npc
);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            instr <= '0;
            npc   <= '0;
        end else if (load) begin
            instr <= instr_in;
            npc   <= npc_in;
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// IF-stage sequencer: owns the PC, handshakes with instruction memory and loads IF/ID.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC),
    parameter int unsigned       MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_mem_pc_src,
    input  logic [ADDR_W-1:0] ex_mem_npc,
    input  logic              id_stall,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       if_id_instr,
    output logic [ADDR_W-1:0] if_id_npc,
    output logic              if_id_valid,
    output logic              fetch_err
);

    localparam int unsigned       CNT_W      = $clog2(MAX_WAIT + 1);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

    fetch_state_t      state, state_n;
    logic [ADDR_W-1:0] pc, pc_n, tgt, tgt_n;
    logic [ADDR_W-1:0] pc_inc, redirect_pc;
    logic [31:0]       instr_n;
    logic [ADDR_W-1:0] npc_n;
    logic              valid_n;
    logic              buf_load, buf_clear;
    logic [31:0]       buf_instr;
    logic [ADDR_W-1:0] buf_npc;
    logic [CNT_W-1:0]  wait_cnt, wait_cnt_n;

    assign imem_req    = (state == FETCH) || (state == DROP);
    assign imem_addr   = pc;
    assign pc_inc      = pc + ADDR_W'(PC_INC);
    assign redirect_pc = ex_mem_npc & ALIGN_MASK;

    fetch_hold_buf #(
        .ADDR_W (ADDR_W)
    ) u_hold_buf (
        .clk      (clk),
        .rst      (rst),
        .load     (buf_load),
        .clear    (buf_clear),
        .instr_in (imem_rdata),
        .npc_in   (pc_inc),
        .instr    (buf_instr),
        .npc      (buf_npc)
    );

    // In DROP, pc keeps the outstanding address and tgt holds the redirect
    // target until the abandoned request is acknowledged.
    always_comb begin
        state_n   = state;
        pc_n      = pc;
        tgt_n     = tgt;
        instr_n   = if_id_instr;
        npc_n     = if_id_npc;
        valid_n   = if_id_valid;
        buf_load  = 1'b0;
        buf_clear = 1'b0;
        unique case (state)
            IDLE: begin
                state_n = FETCH;
                if (ex_mem_pc_src) begin
                    pc_n    = redirect_pc;
                    valid_n = 1'b0;
                    instr_n = NOP;
                end
            end
            FETCH: begin
                if (ex_mem_pc_src) begin
                    valid_n = 1'b0;
                    instr_n = NOP;
                    if (imem_ack) begin
                        pc_n = redirect_pc;
                    end else begin
                        tgt_n   = redirect_pc;
                        state_n = DROP;
                    end
                end else if (imem_ack) begin
                    pc_n = pc_inc;
                    if (id_stall) begin
                        buf_load = 1'b1;
                        state_n  = STALL;
                    end else begin
                        instr_n = imem_rdata;
                        npc_n   = pc_inc;
                        valid_n = 1'b1;
                    end
                end
            end
            DROP: begin
                if (ex_mem_pc_src) begin
                    tgt_n = redirect_pc;
                end
                if (imem_ack) begin
                    pc_n    = ex_mem_pc_src ? redirect_pc : tgt;
                    state_n = FETCH;
                end
            end
            STALL: begin
                if (ex_mem_pc_src) begin
                    pc_n      = redirect_pc;
                    valid_n   = 1'b0;
                    instr_n   = NOP;
                    buf_clear = 1'b1;
                    state_n   = FETCH;
                end else if (!id_stall) begin
                    instr_n   = buf_instr;
                    npc_n     = buf_npc;
                    valid_n   = 1'b1;
                    buf_clear = 1'b1;
                    state_n   = FETCH;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        wait_cnt_n = wait_cnt;
        if (imem_ack) begin
            wait_cnt_n = '0;
        end else if (imem_req && (wait_cnt != CNT_W'(MAX_WAIT))) begin
            wait_cnt_n = wait_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            pc          <= RESET_PC & ALIGN_MASK;
            tgt         <= RESET_PC & ALIGN_MASK;
            if_id_instr <= NOP;
            if_id_npc   <= '0;
            if_id_valid <= 1'b0;
            wait_cnt    <= '0;
            fetch_err   <= 1'b0;
        end else begin
            state       <= state_n;
            pc          <= pc_n;
            tgt         <= tgt_n;
            if_id_instr <= instr_n;
            if_id_npc   <= npc_n;
            if_id_valid <= valid_n;
            wait_cnt    <= wait_cnt_n;
            if (wait_cnt_n == CNT_W'(MAX_WAIT)) begin
                fetch_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed-vector bench for fetch_ctrl with a reactive instruction memory (rdata = addr ^ 0xA5).
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_mem_pc_src;
    logic [31:0] ex_mem_npc;
    logic        id_stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_npc;
    logic        if_id_valid;
    logic        fetch_err;

    int checks   = 0;
    int failures = 0;

    fetch_ctrl #(
        .ADDR_W   (32),
        .RESET_PC (32'h0000_0000),
        .MAX_WAIT (15)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .ex_mem_pc_src (ex_mem_pc_src),
        .ex_mem_npc    (ex_mem_npc),
        .id_stall      (id_stall),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .if_id_instr   (if_id_instr),
        .if_id_npc     (if_id_npc),
        .if_id_valid   (if_id_valid),
        .fetch_err     (fetch_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        pc_src;
        logic [31:0] npc;
        logic        stall;
        logic        ack;
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] instr;
        logic [31:0] inpc;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic src, input logic [31:0] n, input logic st,
                       input logic a, input logic ereq, input logic [31:0] eaddr,
                       input logic ev, input logic [31:0] ei, input logic [31:0] en);
        vec_t v;
        v.rst = r; v.pc_src = src; v.npc = n; v.stall = st; v.ack = a;
        v.req = ereq; v.addr = eaddr; v.valid = ev; v.instr = ei; v.inpc = en;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
    task automatic cycle(input logic r, input logic src, input logic [31:0] n,
                         input logic st, input logic a);
        @(negedge clk);
        rst           = r;
        ex_mem_pc_src = src;
        ex_mem_npc    = n;
        id_stall      = st;
        imem_ack      = a;
        imem_rdata    = imem_addr ^ 32'h0000_00A5;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic ereq, input logic [31:0] eaddr,
                             input logic ev, input logic [31:0] ei, input logic [31:0] en,
                             input logic eerr);
        check({tag, ".req"},   {31'b0, imem_req},    {31'b0, ereq});
        check({tag, ".addr"},  imem_addr,            eaddr);
        check({tag, ".valid"}, {31'b0, if_id_valid}, {31'b0, ev});
        check({tag, ".instr"}, if_id_instr,          ei);
        check({tag, ".npc"},   if_id_npc,            en);
        check({tag, ".err"},   {31'b0, fetch_err},   {31'b0, eerr});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; ex_mem_pc_src = 1'b0; ex_mem_npc = '0; id_stall = 1'b0;
        imem_ack = 1'b0; imem_rdata = '0;

        //   rst src npc           st ack  req addr          v  instr         if_id_npc
        add(1, 0, 32'h0,         0, 0,   0, 32'h0,         0, 32'h0,        32'h0);
        add(1, 0, 32'h0,         0, 0,   0, 32'h0,         0, 32'h0,        32'h0);
        add(0, 0, 32'h0,         0, 0,   1, 32'h0,         0, 32'h0,        32'h0);
        add(0, 0, 32'h0,         0, 1,   1, 32'h4,         1, 32'hA5,       32'h4);
        add(0, 0, 32'h0,         0, 1,   1, 32'h8,         1, 32'hA1,       32'h8);
        add(0, 0, 32'h0,         0, 1,   1, 32'hC,         1, 32'hAD,       32'hC);
        add(0, 0, 32'h0,         0, 1,   1, 32'h10,        1, 32'hA9,       32'h10);
        add(0, 0, 32'h0,         0, 0,   1, 32'h10,        1, 32'hA9,       32'h10);
        add(0, 0, 32'h0,         0, 0,   1, 32'h10,        1, 32'hA9,       32'h10);
        add(0, 0, 32'h0,         0, 1,   1, 32'h14,        1, 32'hB5,       32'h14);
        add(0, 0, 32'h0,         0, 1,   1, 32'h18,        1, 32'hB1,       32'h18);
        add(0, 0, 32'h0,         0, 1,   1, 32'h1C,        1, 32'hBD,       32'h1C);
        add(0, 0, 32'h0,         0, 1,   1, 32'h20,        1, 32'hB9,       32'h20);
        add(0, 0, 32'h0,         1, 0,   1, 32'h20,        1, 32'hB9,       32'h20);
        add(0, 0, 32'h0,         1, 1,   0, 32'h24,        1, 32'hB9,       32'h20);
        add(0, 0, 32'h0,         1, 0,   0, 32'h24,        1, 32'hB9,       32'h20);
        add(0, 0, 32'h0,         1, 0,   0, 32'h24,        1, 32'hB9,       32'h20);
        add(0, 0, 32'h0,         0, 0,   1, 32'h24,        1, 32'h85,       32'h24);
        add(0, 0, 32'h0,         0, 1,   1, 32'h28,        1, 32'h81,       32'h28);
        add(0, 0, 32'h0,         0, 1,   1, 32'h2C,        1, 32'h8D,       32'h2C);
        add(0, 0, 32'h0,         0, 1,   1, 32'h30,        1, 32'h89,       32'h30);
        add(0, 0, 32'h0,         0, 0,   1, 32'h30,        1, 32'h89,       32'h30);
        add(0, 1, 32'h103,       0, 0,   1, 32'h30,        0, 32'h0,        32'h30);
        add(0, 0, 32'h0,         0, 0,   1, 32'h30,        0, 32'h0,        32'h30);
        add(0, 0, 32'h0,         0, 1,   1, 32'h100,       0, 32'h0,        32'h30);
        add(0, 0, 32'h0,         0, 1,   1, 32'h104,       1, 32'h1A5,      32'h104);
        add(0, 1, 32'h200,       1, 1,   1, 32'h200,       0, 32'h0,        32'h104);
        add(0, 0, 32'h0,         0, 1,   1, 32'h204,       1, 32'h2A5,      32'h204);
        add(0, 1, 32'hFFFF_FFFF, 0, 1,   1, 32'hFFFF_FFFC, 0, 32'h0,        32'h204);
        add(0, 0, 32'h0,         0, 1,   1, 32'h0,         1, 32'hFFFF_FF59, 32'h0);
        add(0, 0, 32'h0,         0, 1,   1, 32'h4,         1, 32'hA5,       32'h4);
        add(0, 0, 32'h0,         1, 1,   0, 32'h8,         1, 32'hA5,       32'h4);
        add(0, 1, 32'h40,        1, 0,   1, 32'h40,        0, 32'h0,        32'h4);
        add(0, 0, 32'h0,         0, 1,   1, 32'h44,        1, 32'hE5,       32'h44);

        foreach (vecs[i]) begin
            cycle(vecs[i].rst, vecs[i].pc_src, vecs[i].npc, vecs[i].stall, vecs[i].ack);
            check_all($sformatf("vec%0d", i), vecs[i].req, vecs[i].addr, vecs[i].valid,
                      vecs[i].instr, vecs[i].inpc, 1'b0);
        end

        // Back-to-back redirects while the abandoned request is still outstanding.
        cycle(0, 1, 32'h300, 0, 0);
        check_all("drop1", 1, 32'h44, 0, 32'h0, 32'h44, 0);
        cycle(0, 1, 32'h400, 0, 0);
        check_all("drop2", 1, 32'h44, 0, 32'h0, 32'h44, 0);
        cycle(0, 0, 32'h0, 0, 1);
        check_all("drop_ack", 1, 32'h400, 0, 32'h0, 32'h44, 0);
        cycle(0, 0, 32'h0, 0, 1);
        check_all("drop_next", 1, 32'h404, 1, 32'h4A5, 32'h404, 0);

        // Withheld ack: fetch_err rises on the 15th waiting cycle and is sticky.
        for (int k = 1; k <= 15; k++) begin
            cycle(0, 0, 32'h0, 0, 0);
            check($sformatf("tmo%0d.err", k), {31'b0, fetch_err}, {31'b0, (k >= 15)});
            check($sformatf("tmo%0d.addr", k), imem_addr, 32'h404);
        end
        cycle(0, 0, 32'h0, 0, 1);
        check_all("tmo_ack", 1, 32'h408, 1, 32'h4A1, 32'h408, 1);
        for (int k = 0; k < 3; k++) begin
            cycle(0, 0, 32'h0, 0, 0);
            check($sformatf("tmo_sticky%0d", k), {31'b0, fetch_err}, 32'h1);
        end

        // Reset while a request is pending abandons it.
        cycle(1, 0, 32'h0, 0, 0);
        check_all("rst_mid", 0, 32'h0, 0, 32'h0, 32'h0, 0);
        cycle(0, 0, 32'h0, 0, 0);
        check_all("rst_refetch", 1, 32'h0, 0, 32'h0, 32'h0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Sequencing controller for the IF stage.
- Owns the PC.
- Drives a request/acknowledge instruction-memory port with variable latency.
- Applies decode stalls and EX/MEM redirects.
- Loads the IF/ID pipeline register (instruction, PC+4, valid).
- Sits between the hazard/branch logic and instruction memory, replacing free-running PC update with a handshake-aware FSM.

Parameters:
- ADDR_W, 32, PC/address width.
- RESET_PC, 32'h0000_0000, PC value after reset.
- MAX_WAIT, 15, request cycles without ack before fetch_err sets.

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  synchronous active-high reset (sampled on the clk rising edge)
- ex_mem_pc_src  in  1  redirect request from EX/MEM
- ex_mem_npc  in  ADDR_W  redirect target
- id_stall  in  1  decode stall; IF/ID must hold
- imem_req  out  1  memory request
- imem_addr  out  ADDR_W  request address; bits [1:0] always 0
- imem_ack  in  1  data valid this cycle; may coincide with req (zero-wait)
- imem_rdata  in  32  instruction word
- if_id_instr  out  32  latched instruction
- if_id_npc  out  ADDR_W  latched PC+4
- if_id_valid  out  1  IF/ID holds a real instruction
- fetch_err  out  1  sticky timeout flag

Behaviour:
- Reset values:
  - state=IDLE, pc=RESET_PC
  - imem_req=0, imem_addr=RESET_PC
  - if_id_instr=32'h0 (NOP), if_id_npc=0, if_id_valid=0
  - fetch_err=0, wait_cnt=0
- Reset mid-transaction abandons the outstanding request: no data is captured, and memory must tolerate the withdrawal.
- States: IDLE, FETCH, DROP, STALL.
- IDLE:
  - imem_req=0
  - next cycle -> FETCH (first request one cycle after rst falls).
- FETCH:
  - imem_req=1, imem_addr=pc.
  - Address and req held stable until imem_ack; a request is never withdrawn except by rst.
  - ack & !redirect & !id_stall: if_id_instr<=rdata, if_id_npc<=pc+4, if_id_valid<=1, pc<=pc+4; stay FETCH. Zero-wait memory gives 1 instr/cycle.
  - ack & !redirect & id_stall: IF/ID unchanged; rdata -> hold buffer, pc<=pc+4; -> STALL.
  - No ack & id_stall: IF/ID unchanged; request continues.
- STALL:
  - imem_req=0.
  - When id_stall=0: IF/ID <= buffer (valid=1), npc = buffered pc+4; -> FETCH.
- Redirect (ex_mem_pc_src=1), highest priority, overrides id_stall:
  - if_id_valid<=0, if_id_instr<=NOP, pc<={ex_mem_npc[ADDR_W-1:2],2'b00}.
  - From FETCH with ack the same cycle: data discarded; stay FETCH with the new pc.
  - From FETCH without ack: -> DROP.
  - From STALL: buffer discarded; -> FETCH.
  - From IDLE: pc updated; -> FETCH.
- DROP:
  - imem_req=1 at the old address until ack; the acked data is discarded; -> FETCH with the redirected pc.
  - A further redirect in DROP overwrites the target and stays DROP.
  - if_id_valid stays 0.
- PC arithmetic: pc+4 is modulo 2^ADDR_W, so 32'hFFFF_FFFC wraps to 0.
- Timeout:
  - wait_cnt increments each cycle with imem_req & !imem_ack; clears on ack.
  - When wait_cnt reaches MAX_WAIT, fetch_err<=1.
  - fetch_err is sticky until rst; the request continues regardless.
- Outputs are registered except imem_req and imem_addr, which decode state/pc.

Decomposition:
- Shared package fetch_pkg:
  - state enum (IDLE, FETCH, DROP, STALL)
  - NOP constant 32'h0
  - default RESET_PC
  - PC_INC constant 4
- One sub-module: fetch_hold_buf, a single-entry instruction+PC holding register with load/clear, used by STALL.

Test Plan:
- Zero-wait sequential: rst 2 cycles, ack tied to req, rdata=addr^32'hA5 -> first req one cycle after rst falls at addr 0; IF/ID shows (0xA5, npc 4), then (0xA1, npc 8), one per cycle.
- Wait states: ack 3 cycles after req at addr 0x10 -> imem_addr held at 0x10 for all 3 cycles; IF/ID updates only on the ack cycle with npc 0x14.
- Stall: id_stall high 4 cycles, ack arrives during stall at 0x20 -> IF/ID unchanged, req drops, no new address; on stall release IF/ID=instr@0x20 with npc 0x24; next req at 0x24.
- Redirect during outstanding request: req at 0x30 pending; pulse pc_src with npc=0x103 -> req stays at 0x30 until ack, data dropped, valid=0; next req at 0x100.
- Redirect with stall and ack in the same cycle, npc=0x200 -> flush wins: valid=0, buffer empty, next req at 0x200. Separately: pc=0xFFFF_FFFC ack -> npc 0, next addr 0.
- Timeout: withhold ack 15 cycles -> fetch_err=1 at the 15th cycle, stays 1 after ack; clears only on rst. Reset asserted mid-wait -> next cycle imem_req=0, addr=RESET_PC.
